stopwatch_counter: RTL

- Timebase and BCD time-of-run counter for the stopwatch datapath.
- Divides clk down to a 0.1 s tick and counts tenths, seconds, tens-of-seconds and minutes (M:SS.T) under start/stop/clear control.
- Its four digit outputs feed directly into the lap-hold stage, which freezes or passes the digits to the display driver.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/bcd_digit.sv | 31 +++
 rtl/stopwatch_counter.sv | 95 +++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase: FSM state encoding,
// BCD digit width and the modulus of each display digit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;

    localparam int TENTH_MOD  = 10;
    localparam int SEC_MOD    = 10;
    localparam int TENSEC_MOD = 6;
    localparam int MIN_MOD    = 10;

endpackage

// File: rtl/bcd_digit.sv
// One modulus-MOD BCD digit with synchronous clear and a combinational carry,
// so a chain of these advances every affected digit on the same edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic at_top;

    assign at_top = (q == DIGIT_W'(MOD - 1));
    assign carry  = en && at_top;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_top ? '0 : q + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: prescaler down to a 0.1 s tick, IDLE/RUN/PAUSE control
// and a cascaded M:SS.T BCD counter that rolls over from 9:59.9 to 0:00.0.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int CNT_W    = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    output logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] tenSec,
    output logic [DIGIT_W-1:0] sec,
    output logic [DIGIT_W-1:0] tenthSec,
    output logic               running,
    output logic               tick,
    output logic               wrap
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc;
    logic             run_en;
    logic             tc;
    logic             clr_cnt;
    logic             c_tenth, c_sec, c_tensec, c_min;

    // NOTE: the default assignment first keeps every path covered, so no latch
    // is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && !stop) state_nxt = RUN;
            RUN:     if (stop)           state_nxt = PAUSE;
            PAUSE: begin
                if (clear)               state_nxt = IDLE;
                else if (start && !stop) state_nxt = RUN;
            end
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The cycle carrying a stop pulse is excluded from the count.
    assign run_en  = (state == RUN) && !stop;
    assign tc      = run_en && (presc == CNT_W'(TICK_DIV - 1));
    assign clr_cnt = (state == PAUSE) && clear;
    assign running = (state == RUN);

    // Prescaler holds through PAUSE so a resume finishes the partial tenth.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt || tc) begin
            presc <= '0;
        end else if (run_en) begin
            presc <= presc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= tc;
            wrap <= c_min;
        end
    end

    bcd_digit #(.MOD(TENTH_MOD)) u_tenth (
        .clk(clk), .reset(reset), .clr(clr_cnt), .en(tc),
        .q(tenthSec), .carry(c_tenth)
    );

    bcd_digit #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .clr(clr_cnt), .en(c_tenth),
        .q(sec), .carry(c_sec)
    );

    bcd_digit #(.MOD(TENSEC_MOD)) u_tensec (
        .clk(clk), .reset(reset), .clr(clr_cnt), .en(c_sec),
        .q(tenSec), .carry(c_tensec)
    );

    bcd_digit #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .clr(clr_cnt), .en(c_tensec),
        .q(min), .carry(c_min)
    );

endmodule
